// File: rtl/load_pkg.sv
// Shared types and helpers for the memory-stage load unit.
// Holds the load-type encoding, the control FSM states, the latched
// request context and small decode helpers used by load_unit and load_align.
package load_pkg;

    // Load type as carried in the instruction funct3 field
    typedef enum logic [2:0] {
        F3_LB  = 3'b000,
        F3_LH  = 3'b001,
        F3_LW  = 3'b010,
        F3_LBU = 3'b100,
        F3_LHU = 3'b101
    } funct3_e;

    // Control FSM: accept, address phase, data phase, result strobe
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2,
        ST_RESP = 2'd3
    } state_e;

    // Request information kept from accept until the data is formatted
    typedef struct packed {
        logic [1:0] off;
        logic [2:0] funct3;
    } req_ctx_t;

    // Byte offset bits that are dropped from the issued word address
    localparam int unsigned WORD_OFF_BITS = 2;

    // True for the five load encodings the unit implements
    function automatic logic funct3_legal(input logic [2:0] f3);
        case (f3)
            F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU: funct3_legal = 1'b1;
            default:                             funct3_legal = 1'b0;
        endcase
    endfunction

    // True when the access does not sit on its natural alignment
    function automatic logic access_misaligned(input logic [2:0] f3, input logic [1:0] off);
        case (f3)
            F3_LH, F3_LHU: access_misaligned = off[0];
            F3_LW:         access_misaligned = (off != 2'b00);
            default:       access_misaligned = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/load_align.sv
// Combinational lane select and extension for loaded data.
// Given the read word, the byte offset and the load type, returns the
// byte/halfword/word the instruction asked for, sign- or zero-extended.
// Kept standalone so a later store/AMO path can share it.
module load_align
    import load_pkg::*;
#(
    parameter int XLEN = 32
)
(
    input  logic [XLEN-1:0] rdata,
    input  logic [1:0]      off,
    input  logic [2:0]      funct3,
    output logic [XLEN-1:0] result
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Pick the addressed byte lane and halfword lane out of the read word
    always_comb begin
        byte_sel = rdata[{off, 3'b000} +: 8];
        half_sel = rdata[{off[1], 4'b0000} +: 16];
    end

    // Extend the selected lane as the load type requires
    always_comb begin
        case (funct3)
            F3_LB:   result = {{(XLEN-8){byte_sel[7]}}, byte_sel};
            F3_LBU:  result = {{(XLEN-8){1'b0}}, byte_sel};
            F3_LH:   result = {{(XLEN-16){half_sel[15]}}, half_sel};
            F3_LHU:  result = {{(XLEN-16){1'b0}}, half_sel};
            F3_LW:   result = rdata;
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/load_unit.sv
// Memory-stage load unit sitting between execute and write-back.
// Takes one load request at a time, issues a word-aligned read on the
// data-memory read channel, formats the returned word and emits a single
// cycle result strobe. One load is in flight at most; no overlap.
// Build option: define LOAD_MISALIGN_CHECK_EN to fault misaligned LH/LHU/LW
// requests without touching memory.
module load_unit
    import load_pkg::*;
#(
    parameter int XLEN = 32
)
(
    input  logic            clk,
    input  logic            rstn,
    input  logic            i_req_valid,
    output logic            o_req_ready,
    input  logic [XLEN-1:0] i_req_addr,
    input  logic [2:0]      i_req_funct3,
    output logic            o_dmem_arvalid,
    input  logic            i_dmem_arready,
    output logic [XLEN-1:0] o_dmem_araddr,
    input  logic            i_dmem_rvalid,
    output logic            o_dmem_rready,
    input  logic [XLEN-1:0] i_dmem_rdata,
    input  logic            i_dmem_rerr,
    output logic            o_load_valid,
    output logic [XLEN-1:0] o_load_data,
    output logic            o_load_err
);

    state_e          state;
    state_e          state_nxt;
    req_ctx_t        ctx_q;
    logic [XLEN-1:0] araddr_q;
    logic [XLEN-1:0] data_q;
    logic            err_q;
    logic            req_fire;
    logic            req_reject;
    logic            resp_fire;
    logic [XLEN-1:0] aligned;

    // A request is taken only while idle; a returning beat only in the data phase
    always_comb begin
        req_fire  = (state == ST_IDLE) && i_req_valid;
        resp_fire = (state == ST_DATA) && i_dmem_rvalid;
    end

    // Decide whether an accepted request faults immediately instead of reading memory
    always_comb begin
`ifdef LOAD_MISALIGN_CHECK_EN
        req_reject = !funct3_legal(i_req_funct3) ||
                     access_misaligned(i_req_funct3, i_req_addr[WORD_OFF_BITS-1:0]);
`else
        req_reject = !funct3_legal(i_req_funct3);
`endif
    end

    load_align #(
        .XLEN   (XLEN)
    ) u_align (
        .rdata  (i_dmem_rdata),
        .off    (ctx_q.off),
        .funct3 (ctx_q.funct3),
        .result (aligned)
    );

    // State register; reset abandons any transaction in flight
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic: rejected requests skip straight to the result strobe
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (i_req_valid) begin
                    state_nxt = req_reject ? ST_RESP : ST_ADDR;
                end
            end
            ST_ADDR: begin
                if (i_dmem_arready) begin
                    state_nxt = ST_DATA;
                end
            end
            ST_DATA: begin
                if (i_dmem_rvalid) begin
                    state_nxt = ST_RESP;
                end
            end
            ST_RESP: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Handshake outputs are pure decodes of the current state
    always_comb begin
        o_req_ready    = 1'b0;
        o_dmem_arvalid = 1'b0;
        o_dmem_rready  = 1'b0;
        o_load_valid   = 1'b0;
        case (state)
            ST_IDLE: o_req_ready    = 1'b1;
            ST_ADDR: o_dmem_arvalid = 1'b1;
            ST_DATA: o_dmem_rready  = 1'b1;
            ST_RESP: o_load_valid   = 1'b1;
            default: o_req_ready    = 1'b0;
        endcase
    end

    // Request context, word address and result registers
    always_ff @(posedge clk) begin
        if (!rstn) begin
            ctx_q    <= '0;
            araddr_q <= '0;
            data_q   <= '0;
            err_q    <= 1'b0;
        end else begin
            if (req_fire) begin
                ctx_q.off    <= i_req_addr[WORD_OFF_BITS-1:0];
                ctx_q.funct3 <= i_req_funct3;
                araddr_q     <= {i_req_addr[XLEN-1:WORD_OFF_BITS], {WORD_OFF_BITS{1'b0}}};
                if (req_reject) begin
                    data_q <= '0;
                    err_q  <= 1'b1;
                end
            end
            if (resp_fire) begin
                data_q <= i_dmem_rerr ? '0 : aligned;
                err_q  <= i_dmem_rerr;
            end
        end
    end

    assign o_dmem_araddr = araddr_q;
    assign o_load_data   = data_q;
    assign o_load_err    = err_q;

endmodule

// File: doc/load_unit.md
Name: load_unit

Overview:
- Memory-stage load unit between execute and write-back.
- Accepts one load request per transaction from execute and issues a word-aligned read on the data-memory read channel.
- Extracts and sign- or zero-extends the addressed byte, halfword or word from the response.
- Presents the result as a single-cycle `o_load_valid` pulse with `o_load_data`; this is the source of write-back's `i_load_valid` / `i_load_data`.

Parameters:
- XLEN, 32, data and address width; only 32 is supported.

Ports:
- clk  in  1  clock
- rstn  in  1  reset, synchronous, active-low
- i_req_valid  in  1  load request from execute
- o_req_ready  out  1  unit can accept a request
- i_req_addr  in  XLEN  byte address (rs1+imm)
- i_req_funct3  in  3  load type: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU
- o_dmem_arvalid  out  1  read address valid
- i_dmem_arready  in  1  memory accepts address
- o_dmem_araddr  out  XLEN  word address, bits [1:0] forced to 0
- i_dmem_rvalid  in  1  read data valid
- o_dmem_rready  out  1  unit accepts read data
- i_dmem_rdata  in  XLEN  read word
- i_dmem_rerr  in  1  bus error, qualified by rvalid
- o_load_valid  out  1  one-cycle result strobe
- o_load_data  out  XLEN  extended load result
- o_load_err  out  1  fault flag, qualified by o_load_valid

Behaviour:
- Reset values: state IDLE; o_load_valid, o_load_err, o_dmem_arvalid, o_dmem_rready all 0; o_load_data and o_dmem_araddr 0.
- Reset mid-transaction drops the transaction. Any late rvalid arriving in IDLE is ignored (rready=0).
- FSM states are IDLE, ADDR, DATA, RESP.
- IDLE:
  - o_req_ready=1 (asserted only in IDLE).
  - On i_req_valid, latch addr[1:0] and funct3, and latch the word address.
  - Legal request: go to ADDR.
  - Illegal funct3 (011/110/111): no memory access, set err=1 and data=0, go to RESP.
- ADDR:
  - o_dmem_arvalid=1 with o_dmem_araddr held stable until i_dmem_arready; then go to DATA.
  - Arvalid is never withdrawn before arready.
- DATA:
  - o_dmem_rready=1.
  - On i_dmem_rvalid, register the formatted data and err=i_dmem_rerr; go to RESP.
  - If rerr=1, data=0.
- RESP:
  - o_load_valid=1 for exactly this cycle; o_load_data and o_load_err are valid.
  - Next state is IDLE.
  - o_load_data holds its value after the pulse until the next RESP.
- Latency (accept in cycle 0, arready in cycle 1, rvalid in cycle 2): o_load_valid in cycle 3.
- Throughput: minimum 4 cycles per load. There is no overlap.
- Formatting, with off = addr[1:0]:
  - LB/LBU select byte rdata[8*off +: 8]; LB sign-extends bit 7, LBU zero-extends.
  - LH/LHU select halfword rdata[16*off[1] +: 16]; LH sign-extends bit 15, LHU zero-extends.
  - LW passes rdata through unchanged.
- Simultaneous arready and rvalid in the ADDR cycle: the rvalid is not consumed (rready=0). Memory must hold rvalid until rready.

Optional Feature:
- Macro: LOAD_MISALIGN_CHECK_EN.
- Defined:
  - In IDLE, LH/LHU with addr[0]=1, or LW with addr[1:0]!=0, issue no memory access.
  - The unit goes to RESP with err=1 and data=0.
- Undefined:
  - No check is made. LH/LHU ignore addr[0]; LW ignores addr[1:0].
  - The access proceeds normally with err driven by rerr only.

Decomposition:
- load_pkg holds:
  - the funct3 enum (LB, LH, LW, LBU, LHU);
  - the FSM state enum;
  - a function returning whether a funct3 value is legal.
- Sub-module load_align: combinational byte/halfword select and extension.
  - Inputs: rdata, off, funct3.
  - Output: XLEN result.
  - Reused later by a store/AMO path.

Test Plan:
- LW addr 0x100, memory returns 0xDEADBEEF with arready and rvalid each in their first cycle:
  - araddr=0x100;
  - o_load_valid pulses in cycle 3 with data 0xDEADBEEF, err=0.
- LB addr 0x103, rdata 0x80FF_0011 → data 0xFFFFFF80. The same with LBU → 0x00000080.
- LH addr 0x206, rdata 0x8001_1234 → 0xFFFF8001. The same with LHU → 0x00008001.
- arready held low 5 cycles and rvalid delayed 3 cycles:
  - arvalid and araddr stay stable;
  - o_req_ready=0 throughout;
  - exactly one o_load_valid pulse.
- rvalid with rerr=1 → o_load_valid with err=1, data 0. Funct3 011 → no arvalid, err=1 pulse in cycle 1.
- Misaligned and reset cases:
  - With LOAD_MISALIGN_CHECK_EN, LW addr 0x102 → no arvalid, err=1.
  - Without the macro, the same request gives araddr 0x100, err=0.
  - rstn low in DATA → IDLE next cycle with no o_load_valid.
